tcs_freq_counter: RTL
=====================

// Module: tcs_freq_counter
// PURPOSE
// - Gated frequency counter between the colour-sensor OUT pin and the colour-decision stage.
// - Synchronises the asynchronous square wave and counts rising edges over a fixed gate window.
// - Delivers each count as `frequency` with a one-cycle `begin_flag` strobe.
// - Inserts a settle gap after every strobe so the downstream S2/S3 filter change takes effect
//   before the next window opens.
// PARAMETERS
// - GATE_CYCLES    1_000_000  clock cycles per counting window (10 ms at 100 MHz)
// - SETTLE_CYCLES  200_000    cycles discarded after each strobe, before the next window
// - CNT_W          18         width of edge counter and `frequency`
// PORTS
// - clock        in   1      system clock, all logic on rising edge
// - reset        in   1      synchronous, active-low reset
// - enable       in   1      1 = measure continuously; 0 = idle (driven from CS_state)
// - sensor_out   in   1      asynchronous square wave from sensor OUT pin
// - frequency    out  CNT_W  rising-edge count of the last completed window
// - begin_flag   out  1      one-cycle strobe: `frequency` updated this cycle
// - overflow     out  1      last completed window saturated the counter
// - busy         out  1      1 while in SETTLE or COUNT
// BEHAVIOUR
// - Reset (reset==0 at a clock edge):
//   - frequency=0, begin_flag=0, overflow=0, busy=0.
//   - State=IDLE; synchroniser flops, timer and edge counter cleared.
//   - Reset overrides enable.
// - Input path: 2-flop synchroniser, then a previous-value flop.
//   - edge = sync & ~prev.
//   - An edge is counted 3 clocks after the pin rises.
//   - Pulses shorter than 1 clock may be lost; this is accepted.
// - States:
//   - IDLE: timer=0, count=0, busy=0. enable=1 -> SETTLE.
//   - SETTLE: timer counts 0..SETTLE_CYCLES-1; edges ignored.
//     - At the last cycle, timer=0 and count=0 -> COUNT.
//   - COUNT: timer counts 0..GATE_CYCLES-1; every edge increments count.
//     - count saturates at 2**CNT_W-1 and sets an internal sat bit.
//     - On the last cycle (timer==GATE_CYCLES-1), an edge present that cycle is included.
//     - Next cycle: frequency<=final count, overflow<=sat, begin_flag=1, timer/count/sat cleared.
//     - Then -> SETTLE.
// - begin_flag is high for exactly one cycle per completed window, never twice in a row.
//   - Strobes are spaced exactly SETTLE_CYCLES+GATE_CYCLES+1 cycles apart while enable stays 1.
// - frequency/overflow change only with begin_flag; they hold between strobes and while in IDLE.
// - enable falls in SETTLE or COUNT: next cycle -> IDLE.
//   - Partial window discarded, no strobe; frequency/overflow unchanged.
// - enable rises again: always starts with a full SETTLE. There is no resume of a partial window.
// - enable falls on the strobe cycle: the strobe still completes; then -> IDLE.
// - Timer width is $clog2(max(GATE_CYCLES,SETTLE_CYCLES)). The timer never wraps; it is cleared
//   explicitly at each state change.
// - SETTLE_CYCLES=0 is legal: SETTLE lasts 1 cycle.
// TESTING (bench uses GATE_CYCLES=100, SETTLE_CYCLES=20 unless noted)
// 1. Hold reset=0 for 5 cycles with sensor toggling.
//    -> frequency=0, begin_flag=0, overflow=0, busy=0 throughout.
// 2. enable=1, sensor period 10 clk, edges phased away from window boundaries.
//    -> first begin_flag 121 cycles after the SETTLE entry cycle; frequency=10, overflow=0.
//    -> strobes repeat every 121 cycles.
// 3. CNT_W=4, sensor toggling every clock (50 edges per window).
//    -> frequency=15, overflow=1.
//    -> then sensor period 20: next window frequency=5, overflow=0.
// 4. enable dropped at timer=50 of COUNT.
//    -> no begin_flag; frequency keeps previous value; busy=0 next cycle.
//    -> re-enable gives first strobe 121 cycles later.
// 5. reset asserted mid-COUNT with frequency=10.
//    -> next cycle frequency=0, state IDLE.
//    -> after release with enable=1, normal strobes resume (frequency=10).
// 6. Single sensor edge placed on the last COUNT cycle (pin 3 clk earlier).
//    -> counted in that window's frequency, not the next.

Source files
------------

// File: rtl/tcs_freq_counter.sv
// Gated frequency counter: synchronises the colour-sensor square wave, counts rising edges
// over a fixed gate window and strobes the result, with a settle gap before each window.
module tcs_freq_counter #(
    parameter int GATE_CYCLES   = 1_000_000,
    parameter int SETTLE_CYCLES = 200_000,
    parameter int CNT_W         = 18
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             sensor_out,
    output logic [CNT_W-1:0] frequency,
    output logic             begin_flag,
    output logic             overflow,
    output logic             busy
);

    localparam int MAX_CYC = (GATE_CYCLES > SETTLE_CYCLES) ? GATE_CYCLES : SETTLE_CYCLES;
    localparam int TW      = $clog2((MAX_CYC < 2) ? 2 : MAX_CYC);
    localparam logic [TW-1:0]    GATE_LAST   = TW'(GATE_CYCLES - 1);
    localparam logic [TW-1:0]    SETTLE_LAST = TW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_COUNT,
        S_DONE
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_timer;
    logic [CNT_W-1:0] r_cnt;
    logic             r_sat;
    logic             r_sync_p0;
    logic             r_sync_p1;
    logic             r_prev_p2;
    logic [CNT_W-1:0] r_frequency;
    logic             r_overflow;
    logic             r_begin_flag;
    logic             w_edge;
    logic             w_fire;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_sat_nxt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic inc);
        if (inc && (v != CNT_MAX))
            return v + CNT_W'(1);
        return v;
    endfunction

    assign w_edge    = r_sync_p1 & ~r_prev_p2;
    assign w_cnt_nxt = sat_inc(r_cnt, w_edge);
    assign w_sat_nxt = r_sat | (w_edge & (r_cnt == CNT_MAX));
    // The edge seen on the final gate cycle still belongs to this window.
    assign w_fire    = (r_state == S_COUNT) && (w_state_nxt == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:   if (enable) w_state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (!enable)                     w_state_nxt = S_IDLE;
                else if (r_timer == SETTLE_LAST) w_state_nxt = S_COUNT;
            end
            S_COUNT:  begin
                if (!enable)                   w_state_nxt = S_IDLE;
                else if (r_timer == GATE_LAST) w_state_nxt = S_DONE;
            end
            S_DONE:   w_state_nxt = enable ? S_SETTLE : S_IDLE;
            default:  w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_cnt        <= '0;
            r_sat        <= 1'b0;
            r_sync_p0    <= 1'b0;
            r_sync_p1    <= 1'b0;
            r_prev_p2    <= 1'b0;
            r_frequency  <= '0;
            r_overflow   <= 1'b0;
            r_begin_flag <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_sync_p0 <= sensor_out;
            r_sync_p1 <= r_sync_p0;
            r_prev_p2 <= r_sync_p1;

            if ((w_state_nxt == r_state) && ((r_state == S_SETTLE) || (r_state == S_COUNT)))
                r_timer <= r_timer + TW'(1);
            else
                r_timer <= '0;

            if ((r_state == S_COUNT) && (w_state_nxt == S_COUNT)) begin
                r_cnt <= w_cnt_nxt;
                r_sat <= w_sat_nxt;
            end else begin
                r_cnt <= '0;
                r_sat <= 1'b0;
            end

            r_begin_flag <= w_fire;
            if (w_fire) begin
                r_frequency <= w_cnt_nxt;
                r_overflow  <= w_sat_nxt;
            end
        end
    end

    assign frequency  = r_frequency;
    assign overflow   = r_overflow;
    assign begin_flag = r_begin_flag;
    assign busy       = (r_state == S_SETTLE) || (r_state == S_COUNT);

endmodule
